// File: rtl/nlc_pkg.sv
// Shared constants, FSM state encoding and channel-slice helper for the NLC
// channel dispatcher.
package nlc_pkg;

    localparam int NLC_NCH = 16;
    localparam int NLC_XW  = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } nlc_state_e;

    // Extract channel c from a flat frame packed as [c*XW +: XW].
    function automatic logic [NLC_XW-1:0] ch_slice(
        input logic [NLC_NCH*NLC_XW-1:0] flat,
        input logic [3:0]                c
    );
        return flat[int'(c)*NLC_XW +: NLC_XW];
    endfunction

endpackage

// File: rtl/nlc_frame_buf.sv
// NCH x XW register array: whole-frame snapshot load, single-index write,
// flat read-out in [c*XW +: XW] packing.
module nlc_frame_buf
    import nlc_pkg::*;
#(
    parameter int NCH = NLC_NCH,
    parameter int XW  = NLC_XW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [NCH*XW-1:0] load_data,
    input  logic              wr_en,
    input  logic [3:0]        wr_idx,
    input  logic [XW-1:0]     wr_data,
    output logic [NCH*XW-1:0] rd_data
);

    logic [NCH*XW-1:0] mem_d;
    logic [NCH*XW-1:0] mem_q;

    // Snapshot load takes priority over a single-channel write.
    always_comb begin
        mem_d = mem_q;
        if (load) begin
            mem_d = load_data;
        end else if (wr_en) begin
            mem_d[int'(wr_idx)*XW +: XW] = wr_data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q;

endmodule

// File: rtl/nlc_ch_dispatch.sv
// Sequences a 16-channel frame through the single-channel NLC core and
// re-assembles the results. Optional overrun counter: NLC_DISPATCH_OVERRUN_EN.
module nlc_ch_dispatch
    import nlc_pkg::*;
#(
    parameter int NCH         = NLC_NCH,
    parameter int XW          = NLC_XW,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              srdyi,
    input  logic [NCH*XW-1:0] x_adc,
    output logic              busy,
    output logic              core_srdyi,
    output logic [3:0]        core_ch,
    output logic [XW-1:0]     core_x_adc,
    input  logic              core_srdyo,
    input  logic [XW-1:0]     core_x_lin,
    output logic              srdyo,
    output logic [NCH*XW-1:0] x_lin,
`ifdef NLC_DISPATCH_OVERRUN_EN
    output logic [7:0]        overrun_cnt,
`endif
    output logic              timeout_o
);

    nlc_state_e        state_d, state_q;
    logic [3:0]        ch_d, ch_q;
    logic [7:0]        wait_cnt_d, wait_cnt_q;
    logic              timeout_d, timeout_q;
    logic              busy_d, busy_q;
    logic              core_srdyi_d, core_srdyi_q;
    logic [3:0]        core_ch_d, core_ch_q;
    logic [XW-1:0]     core_x_adc_d, core_x_adc_q;
    logic              srdyo_d, srdyo_q;
    logic [NCH*XW-1:0] x_lin_d, x_lin_q;

    logic              frame_load;
    logic              res_wr;
    logic [XW-1:0]     res_data;
    logic              advance;
    logic              timeout_hit;
    logic [NCH*XW-1:0] frame_flat;
    logic [NCH*XW-1:0] result_flat;

    nlc_frame_buf #(.NCH(NCH), .XW(XW)) u_frame (
        .clk       (clk),
        .reset     (reset),
        .load      (frame_load),
        .load_data (x_adc),
        .wr_en     (1'b0),
        .wr_idx    (4'd0),
        .wr_data   ({XW{1'b0}}),
        .rd_data   (frame_flat)
    );

    nlc_frame_buf #(.NCH(NCH), .XW(XW)) u_result (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .load_data ({(NCH*XW){1'b0}}),
        .wr_en     (res_wr),
        .wr_idx    (ch_q),
        .wr_data   (res_data),
        .rd_data   (result_flat)
    );

    assign timeout_hit = ((wait_cnt_q + 8'd1) == 8'(TIMEOUT_CYC));

    // Next-state and registered-output computation; issue strobe, channel and
    // sample are set on entry to ISSUE so they line up with the ISSUE cycle.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        core_srdyi_d = 1'b0;
        core_ch_d    = core_ch_q;
        core_x_adc_d = core_x_adc_q;
        srdyo_d      = 1'b0;
        x_lin_d      = x_lin_q;
        frame_load   = 1'b0;
        res_wr       = 1'b0;
        res_data     = {XW{1'b0}};
        advance      = 1'b0;
        case (state_q)
            IDLE: begin
                if (srdyi) begin
                    frame_load   = 1'b1;
                    ch_d         = 4'd0;
                    state_d      = ISSUE;
                    core_srdyi_d = 1'b1;
                    core_ch_d    = 4'd0;
                    core_x_adc_d = x_adc[XW-1:0];
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                wait_cnt_d = 8'd0;
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (core_srdyo) begin
                    res_wr   = 1'b1;
                    res_data = core_x_lin;
                    advance  = 1'b1;
                end else if (timeout_hit) begin
                    res_wr    = 1'b1;
                    res_data  = {XW{1'b0}};
                    timeout_d = 1'b1;
                    advance   = 1'b1;
                end else begin
                    advance = 1'b0;
                end
                if (advance) begin
                    if (ch_q == 4'(NCH-1)) begin
                        // Last result is merged here so x_lin is whole while srdyo is high.
                        state_d = DONE;
                        srdyo_d = 1'b1;
                        x_lin_d = {res_data, result_flat[(NCH-1)*XW-1:0]};
                    end else begin
                        ch_d         = ch_q + 4'd1;
                        state_d      = ISSUE;
                        core_srdyi_d = 1'b1;
                        core_ch_d    = ch_q + 4'd1;
                        core_x_adc_d = ch_slice(frame_flat, ch_q + 4'd1);
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ch_q         <= 4'd0;
            wait_cnt_q   <= 8'd0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            core_srdyi_q <= 1'b0;
            core_ch_q    <= 4'd0;
            core_x_adc_q <= {XW{1'b0}};
            srdyo_q      <= 1'b0;
            x_lin_q      <= {(NCH*XW){1'b0}};
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            core_srdyi_q <= core_srdyi_d;
            core_ch_q    <= core_ch_d;
            core_x_adc_q <= core_x_adc_d;
            srdyo_q      <= srdyo_d;
            x_lin_q      <= x_lin_d;
        end
    end

    assign busy       = busy_q;
    assign core_srdyi = core_srdyi_q;
    assign core_ch    = core_ch_q;
    assign core_x_adc = core_x_adc_q;
    assign srdyo      = srdyo_q;
    assign x_lin      = x_lin_q;
    assign timeout_o  = timeout_q;

`ifdef NLC_DISPATCH_OVERRUN_EN
    logic [7:0] overrun_cnt_d, overrun_cnt_q;

    // Count frames dropped because a frame is still in flight (DONE included).
    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (srdyi && busy_q && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end else begin
            overrun_cnt_d = overrun_cnt_q;
        end
    end

    // Overrun counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt_q <= 8'd0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

endmodule

// File: tb/tb_nlc_ch_dispatch.sv
// Directed bench for nlc_ch_dispatch with a latency-programmable core model.
module tb_nlc_ch_dispatch;

    localparam int NCH = 16;
    localparam int XW  = 21;
    localparam int TO  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              srdyi;
    logic [NCH*XW-1:0] x_adc;
    logic              busy;
    logic              core_srdyi;
    logic [3:0]        core_ch;
    logic [XW-1:0]     core_x_adc;
    logic              core_srdyo = 1'b0;
    logic [XW-1:0]     core_x_lin = '0;
    logic              srdyo;
    logic [NCH*XW-1:0] x_lin;
    logic              timeout_o;
`ifdef NLC_DISPATCH_OVERRUN_EN
    logic [7:0]        overrun_cnt;
`endif

    int errors = 0;
    int checks = 0;

    int            lat_tab[NCH];
    int            noreply_ch = -1;
    int            left = 0;
    logic [XW-1:0] pend = '0;
    bit            drop = 1'b0;
    int            issue_log[$];

    nlc_ch_dispatch #(.NCH(NCH), .XW(XW), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .srdyi      (srdyi),
        .x_adc      (x_adc),
        .busy       (busy),
        .core_srdyi (core_srdyi),
        .core_ch    (core_ch),
        .core_x_adc (core_x_adc),
        .core_srdyo (core_srdyo),
        .core_x_lin (core_x_lin),
        .srdyo      (srdyo),
        .x_lin      (x_lin),
`ifdef NLC_DISPATCH_OVERRUN_EN
        .overrun_cnt(overrun_cnt),
`endif
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    // Core model: answers x_adc+100 lat_tab[ch] cycles after the issue cycle.
    always @(negedge clk) begin
        core_srdyo = 1'b0;
        if (left > 0) begin
            left--;
            if (left == 0 && !drop) begin
                core_srdyo = 1'b1;
                core_x_lin = pend + XW'(100);
            end
        end
        if (core_srdyi === 1'b1) begin
            issue_log.push_back(int'(core_ch));
            left = lat_tab[core_ch];
            pend = core_x_adc;
            drop = (int'(core_ch) == noreply_ch);
        end
    end

    task automatic start_frame(input int base);
        for (int c = 0; c < NCH; c++) x_adc[c*XW +: XW] = XW'(base + c);
        srdyi = 1'b1;
        @(negedge clk);
        srdyi = 1'b0;
    endtask

    task automatic wait_srdyo(input int start, output int lat);
        lat = start;
        while (srdyo !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        srdyi = 1'b0;
        x_adc = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, srdyo, core_srdyi, timeout_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, srdyo, core_srdyi, timeout_o});
        end
        checks++;
        if (x_lin !== '0 || core_ch !== 4'd0 || core_x_adc !== '0) begin
            errors++;
            $display("FAIL reset_data: got x_lin=%h ch=%0d xadc=%0d expected zeros", x_lin, core_ch, core_x_adc);
        end
`ifdef NLC_DISPATCH_OVERRUN_EN
        checks++;
        if (overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int lat;
        issue_log.delete();
        start_frame(1);
        wait_srdyo(1, lat);
        checks++;
        if (lat !== 81) begin
            errors++;
            $display("FAIL nominal_latency: got %0d expected 81", lat);
        end
        checks++;
        if (issue_log.size() !== 16) begin
            errors++;
            $display("FAIL nominal_issue_count: got %0d expected 16", issue_log.size());
        end
        for (int i = 0; i < issue_log.size(); i++) begin
            checks++;
            if (issue_log[i] !== i) begin
                errors++;
                $display("FAIL nominal_core_ch[%0d]: got %0d expected %0d", i, issue_log[i], i);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (x_lin[c*XW +: XW] !== XW'(c + 101)) begin
                errors++;
                $display("FAIL nominal_x_lin ch%0d: got %0d expected %0d", c, x_lin[c*XW +: XW], c + 101);
            end
        end
        @(negedge clk);
        checks++;
        if (srdyo !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL nominal_after: got srdyo=%b busy=%b expected 0 0", srdyo, busy);
        end
    endtask

    task automatic test_race();
        int lat;
        lat_tab[3] = TO;
        start_frame(200);
        wait_srdyo(1, lat);
        lat_tab[3] = 4;
        checks++;
        if (lat !== 85) begin
            errors++;
            $display("FAIL race_latency: got %0d expected 85", lat);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (x_lin[c*XW +: XW] !== XW'(c + 300)) begin
                errors++;
                $display("FAIL race_x_lin ch%0d: got %0d expected %0d", c, x_lin[c*XW +: XW], c + 300);
            end
        end
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL race_timeout: got %b expected 0", timeout_o);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        int lat;
        start_frame(400);
        repeat (9) @(negedge clk);
        for (int c = 0; c < NCH; c++) x_adc[c*XW +: XW] = XW'(9000 + c);
        srdyi = 1'b1;
        @(negedge clk);
        srdyi = 1'b0;
        wait_srdyo(11, lat);
        checks++;
        if (lat !== 81) begin
            errors++;
            $display("FAIL overrun_latency: got %0d expected 81", lat);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (x_lin[c*XW +: XW] !== XW'(c + 500)) begin
                errors++;
                $display("FAIL overrun_x_lin ch%0d: got %0d expected %0d", c, x_lin[c*XW +: XW], c + 500);
            end
        end
`ifdef NLC_DISPATCH_OVERRUN_EN
        checks++;
        if (overrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL overrun_cnt: got %0d expected 1", overrun_cnt);
        end
`endif
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_dropped: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int l1;
        int l2;
        start_frame(1000);
        wait_srdyo(1, l1);
        checks++;
        if (l1 !== 81) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d expected 81", l1);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (x_lin[c*XW +: XW] !== XW'(c + 1100)) begin
                errors++;
                $display("FAIL b2b_first_x_lin ch%0d: got %0d expected %0d", c, x_lin[c*XW +: XW], c + 1100);
            end
        end
        @(negedge clk);
        start_frame(2000);
        wait_srdyo(1, l2);
        checks++;
        if (l2 + 1 !== 82) begin
            errors++;
            $display("FAIL b2b_period: got %0d expected 82", l2 + 1);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (x_lin[c*XW +: XW] !== XW'(c + 2100)) begin
                errors++;
                $display("FAIL b2b_second_x_lin ch%0d: got %0d expected %0d", c, x_lin[c*XW +: XW], c + 2100);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int lat;
        noreply_ch = 5;
        start_frame(3000);
        wait_srdyo(1, lat);
        noreply_ch = -1;
        checks++;
        if (lat !== 85) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected 85", lat);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (x_lin[c*XW +: XW] !== ((c == 5) ? XW'(0) : XW'(c + 3100))) begin
                errors++;
                $display("FAIL timeout_x_lin ch%0d: got %0d expected %0d", c, x_lin[c*XW +: XW],
                         (c == 5) ? 0 : c + 3100);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b expected 1", timeout_o);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int lat;
        bit seen;
        start_frame(4000);
        n = 1;
        while (!(busy === 1'b1 && core_ch === 4'd7 && core_srdyi === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL reset_mid_reach_ch7: got timeout after %0d cycles expected WAIT of ch7", n);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || srdyo !== 1'b0 || timeout_o !== 1'b0 || x_lin !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: got busy=%b srdyo=%b to=%b x_lin=%h expected all 0",
                     busy, srdyo, timeout_o, x_lin);
        end
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (srdyo === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got activity=%b expected 0", seen);
        end
        start_frame(5000);
        wait_srdyo(1, lat);
        checks++;
        if (lat !== 81) begin
            errors++;
            $display("FAIL reset_mid_next_latency: got %0d expected 81", lat);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (x_lin[c*XW +: XW] !== XW'(c + 5100)) begin
                errors++;
                $display("FAIL reset_mid_next_x_lin ch%0d: got %0d expected %0d", c, x_lin[c*XW +: XW], c + 5100);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) lat_tab[i] = 4;
        reset = 1'b1;
        srdyi = 1'b0;
        x_adc = '0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_race();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
